// File: rtl/prm_edge_sweep_if.sv
// Request/checker/result bundle between the edge scheduler, prm_edge_sweep and the
// combinational checker bank. The slave modport is the sweeper's view.
interface prm_edge_sweep_if #(
   parameter int JW   = 5,
   parameter int NJ   = 3,
   parameter int SLOG = 4
);
   localparam int CW = JW * NJ;

   logic            req_valid;
   logic            req_ready;
   logic [CW-1:0]   req_start;
   logic [CW-1:0]   req_end;
   logic            abort;
   logic [CW-1:0]   cell_code;
   logic            cell_vld;
   logic            edge_mask;
   logic            res_vld;
   logic            res_hit;
   logic [SLOG:0]   res_idx;
   logic            busy;

   modport master (
      output req_valid, req_start, req_end, abort, edge_mask,
      input  req_ready, cell_code, cell_vld, res_vld, res_hit, res_idx, busy
   );

   modport slave (
      input  req_valid, req_start, req_end, abort, edge_mask,
      output req_ready, cell_code, cell_vld, res_vld, res_hit, res_idx, busy
   );
endinterface

// File: rtl/prm_edge_sweep.sv
// Walks one roadmap edge cell by cell through the checker bank using per-joint
// fixed-point interpolation, and reports the first obstructed step (if any).
module prm_edge_sweep #(
   parameter int JW   = 5,
   parameter int NJ   = 3,
   parameter int SLOG = 4
) (
   input logic                clk,
   input logic                rst,
   prm_edge_sweep_if.slave    bus
);
   localparam int CW    = JW * NJ;
   localparam int STEPS = 2 ** SLOG;
   localparam int AW    = JW + SLOG + 1;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          start_q, start_d;
   logic signed [JW:0]     diff_q [NJ];
   logic signed [JW:0]     diff_d [NJ];
   logic signed [AW-1:0]   acc_q  [NJ];
   logic signed [AW-1:0]   acc_d  [NJ];
   logic [SLOG:0]          k_q, k_d;
   logic                   req_ready_q, req_ready_d;
   logic [CW-1:0]          cell_code_q, cell_code_d;
   logic                   cell_vld_q, cell_vld_d;
   logic                   res_vld_q, res_vld_d;
   logic                   res_hit_q, res_hit_d;
   logic [SLOG:0]          res_idx_q, res_idx_d;
   logic                   busy_q, busy_d;

   // acc holds diff*k, so the arithmetic shift is floor(diff*k/STEPS) for either sign.
   function automatic logic [JW-1:0] interp(input logic [JW-1:0] s,
                                            input logic signed [AW-1:0] acc);
      logic signed [AW-1:0] sum;
      sum = $signed({{(AW-JW){1'b0}}, s}) + (acc >>> SLOG);
      return sum[JW-1:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      k_d         = k_q;
      req_ready_d = req_ready_q;
      cell_code_d = cell_code_q;
      cell_vld_d  = cell_vld_q;
      res_vld_d   = 1'b0;
      res_hit_d   = res_hit_q;
      res_idx_d   = res_idx_q;
      busy_d      = busy_q;
      for (int j = 0; j < NJ; j++) begin
         diff_d[j] = diff_q[j];
         acc_d[j]  = acc_q[j];
      end

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               start_d = bus.req_start;
               for (int j = 0; j < NJ; j++) begin
                  diff_d[j] = $signed({1'b0, bus.req_end[j*JW +: JW]})
                            - $signed({1'b0, bus.req_start[j*JW +: JW]});
                  acc_d[j]  = '0;
               end
               k_d         = '0;
               cell_code_d = bus.req_start;
               cell_vld_d  = 1'b1;
               req_ready_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = SWEEP;
            end
         end
         SWEEP: begin
            if (bus.abort) begin
               cell_vld_d  = 1'b0;
               req_ready_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end else if (bus.edge_mask) begin
               res_hit_d  = 1'b1;
               res_idx_d  = k_q;
               res_vld_d  = 1'b1;
               cell_vld_d = 1'b0;
               state_d    = DONE;
            end else if (k_q == (SLOG+1)'(STEPS)) begin
               res_hit_d  = 1'b0;
               res_idx_d  = '0;
               res_vld_d  = 1'b1;
               cell_vld_d = 1'b0;
               state_d    = DONE;
            end else begin
               k_d = k_q + 1'b1;
               for (int j = 0; j < NJ; j++) begin
                  acc_d[j] = acc_q[j] + $signed({{(AW-JW-1){diff_q[j][JW]}}, diff_q[j]});
                  cell_code_d[j*JW +: JW] = interp(start_q[j*JW +: JW], acc_d[j]);
               end
            end
         end
         DONE: begin
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            req_ready_d = 1'b1;
            cell_vld_d  = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         start_q     <= '0;
         k_q         <= '0;
         req_ready_q <= 1'b1;
         cell_code_q <= '0;
         cell_vld_q  <= 1'b0;
         res_vld_q   <= 1'b0;
         res_hit_q   <= 1'b0;
         res_idx_q   <= '0;
         busy_q      <= 1'b0;
         for (int j = 0; j < NJ; j++) begin
            diff_q[j] <= '0;
            acc_q[j]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         k_q         <= k_d;
         req_ready_q <= req_ready_d;
         cell_code_q <= cell_code_d;
         cell_vld_q  <= cell_vld_d;
         res_vld_q   <= res_vld_d;
         res_hit_q   <= res_hit_d;
         res_idx_q   <= res_idx_d;
         busy_q      <= busy_d;
         for (int j = 0; j < NJ; j++) begin
            diff_q[j] <= diff_d[j];
            acc_q[j]  <= acc_d[j];
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.cell_code = cell_code_q;
   assign bus.cell_vld  = cell_vld_q;
   assign bus.res_vld   = res_vld_q;
   assign bus.res_hit   = res_hit_q;
   assign bus.res_idx   = res_idx_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_prm_edge_sweep.sv
// Randomized bench for prm_edge_sweep: a per-cycle expectation timeline is built from
// an edge-level model (floor interpolation, first-hit search) and compared every cycle.
module tb_prm_edge_sweep;
   localparam int JW    = 5;
   localparam int NJ    = 3;
   localparam int SLOG  = 4;
   localparam int CW    = JW * NJ;
   localparam int STEPS = 2 ** SLOG;
   localparam int MAXC  = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   initial forever #5 clk = ~clk;

   prm_edge_sweep_if #(.JW(JW), .NJ(NJ), .SLOG(SLOG)) bus ();

   prm_edge_sweep #(.JW(JW), .NJ(NJ), .SLOG(SLOG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic          hit_en   = 1'b0;
   logic [CW-1:0] hit_code = '0;
   logic          noise    = 1'b0;
   assign bus.edge_mask = bus.cell_vld ? (hit_en && (bus.cell_code == hit_code)) : noise;

   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   bit  chk_en = 1'b0;
   int  last_res_cyc = -1;
   int  res_cnt = 0;
   int  vld_cnt = 0;

   bit  exp_ready [MAXC];
   bit  exp_busy  [MAXC];
   bit  exp_vld   [MAXC];
   bit  exp_rv    [MAXC];
   int  exp_code  [MAXC];
   int  exp_hit   [MAXC];
   int  exp_idx   [MAXC];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic int fdiv(input int num);
      if (num >= 0) return num / STEPS;
      return -((-num + STEPS - 1) / STEPS);
   endfunction

   // Cell k of the edge s->e: each joint moves floor(diff*k/STEPS) from its start.
   function automatic int qcell(input int s, input int e, input int k);
      int r = 0;
      int m = (1 << JW) - 1;
      for (int j = 0; j < NJ; j++) begin
         int sj = (s >> (JW*j)) & m;
         int ej = (e >> (JW*j)) & m;
         r = r | ((sj + fdiv((ej - sj) * k)) << (JW*j));
      end
      return r;
   endfunction

   function automatic void idle_fill(input int c0);
      for (int c = c0; c < MAXC; c++) begin
         exp_ready[c] = 1'b1; exp_busy[c] = 1'b0; exp_vld[c] = 1'b0; exp_rv[c] = 1'b0;
         exp_code[c] = 0; exp_hit[c] = 0; exp_idx[c] = 0;
      end
   endfunction

   // Request accepted in cycle t; abort asserted in cycle a (a<0: none).
   function automatic void schedule(input int t, input int s, input int e,
                                    input bit hen, input int hc, input int a);
      int kend = STEPS;
      bit hit  = 1'b0;
      int last, endc;
      bit ab;
      for (int k = 0; k <= STEPS; k++) begin
         if (hen && qcell(s, e, k) == hc) begin
            kend = k; hit = 1'b1; break;
         end
      end
      last = t + 1 + kend;
      ab   = (a >= t + 1) && (a <= last);
      endc = ab ? a : last;
      for (int c = t + 1; c <= endc; c++) begin
         exp_ready[c] = 1'b0; exp_busy[c] = 1'b1; exp_vld[c] = 1'b1;
         exp_code[c] = qcell(s, e, c - t - 1);
      end
      if (ab) return;
      exp_ready[last+1] = 1'b0; exp_busy[last+1] = 1'b1; exp_rv[last+1] = 1'b1;
      for (int c = last + 1; c < MAXC; c++) begin
         exp_hit[c] = hit ? 1 : 0;
         exp_idx[c] = hit ? kend : 0;
      end
   endfunction

   initial forever begin
      @(negedge clk);
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      if (chk_en) begin
         chk("req_ready", int'(bus.req_ready), int'(exp_ready[cyc]));
         chk("busy",      int'(bus.busy),      int'(exp_busy[cyc]));
         chk("cell_vld",  int'(bus.cell_vld),  int'(exp_vld[cyc]));
         chk("res_vld",   int'(bus.res_vld),   int'(exp_rv[cyc]));
         chk("res_hit",   int'(bus.res_hit),   exp_hit[cyc]);
         chk("res_idx",   int'(bus.res_idx),   exp_idx[cyc]);
         if (exp_vld[cyc]) chk("cell_code", int'(bus.cell_code), exp_code[cyc]);
      end
      if (bus.res_vld) begin
         last_res_cyc = cyc;
         res_cnt++;
      end
      if (bus.cell_vld) vld_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
      noise = 1'($urandom_range(0, 1));
      if (exp_ready[cyc]) begin
         bus.req_valid = 1'b0;
      end else begin
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_start = CW'($urandom);
         bus.req_end   = CW'($urandom);
      end
      bus.abort = (!exp_busy[cyc] || exp_rv[cyc]) ? ($urandom_range(0, 3) == 0) : 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!exp_ready[cyc]) begin
         step();
         guard++;
         if (guard > 100) begin
            $display("FAIL idle_timeout cyc=%0d", cyc);
            $fatal(1, "idle timeout");
         end
      end
   endtask

   task automatic do_edge(input int s, input int e, input bit hen, input int hc,
                          input int aoff, output int t);
      wait_idle();
      hit_en        = hen;
      hit_code      = hc[CW-1:0];
      bus.req_valid = 1'b1;
      bus.req_start = s[CW-1:0];
      bus.req_end   = e[CW-1:0];
      t = cyc;
      schedule(t, s, e, hen, hc, (aoff > 0) ? t + aoff : -1);
      if (aoff > 0) begin
         for (int i = 0; i < aoff; i++) step();
         bus.abort = 1'b1;
      end else begin
         step();
      end
   endtask

   initial begin
      int t, t2, r0, c0, s, e, hc, aoff, sel;
      bit hen;
      bus.req_valid = 1'b0;
      bus.req_start = '0;
      bus.req_end   = '0;
      bus.abort     = 1'b0;
      idle_fill(0);

      chk("model_k8",  qcell(0, 'h7FFF, 8),  'h3DEF);
      chk("model_k16", qcell(0, 'h7FFF, 16), 'h7FFF);
      chk("model_dn1", qcell('h7FFF, 0, 1),  'h77BD);

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_ready",  int'(bus.req_ready), 1);
      chk("rst_busy",   int'(bus.busy),      0);
      chk("rst_vld",    int'(bus.cell_vld),  0);
      chk("rst_code",   int'(bus.cell_code), 0);
      chk("rst_resvld", int'(bus.res_vld),   0);
      chk("rst_hit",    int'(bus.res_hit),   0);
      chk("rst_idx",    int'(bus.res_idx),   0);
      rst    = 1'b0;
      chk_en = 1'b1;

      vld_cnt = 0;
      do_edge(0, 0, 1'b0, 0, -1, t);
      wait_idle();
      chk("t1_res_cycle", last_res_cyc, t + 18);
      chk("t1_cells", vld_cnt, 17);
      chk("t1_hit", int'(bus.res_hit), 0);

      do_edge(0, 'h7FFF, 1'b0, 0, -1, t);
      do_edge('h7FFF, 0, 1'b0, 0, -1, t);

      do_edge(0, 'h7FFF, 1'b1, qcell(0, 'h7FFF, 5), -1, t);
      wait_idle();
      chk("t4_res_cycle", last_res_cyc, t + 7);
      chk("t4_hit", int'(bus.res_hit), 1);
      chk("t4_idx", int'(bus.res_idx), 5);

      r0 = res_cnt;
      do_edge('h1234, 'h5A5A, 1'b0, 0, 4, t);
      do_edge('h0421, 'h7C1F, 1'b0, 0, -1, t2);
      chk("t5_restart", t2, t + 5);
      chk("t5_nores", res_cnt - r0, 0);
      wait_idle();
      chk("t5_res_cycle", last_res_cyc, t2 + 18);

      do_edge('h2222, 'h6D3B, 1'b0, 0, -1, t);
      repeat (5) step();
      hit_en        = 1'b0;
      rst           = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_start = 15'h0C63;
      bus.req_end   = 15'h7318;
      bus.abort     = 1'b0;
      c0 = cyc;
      idle_fill(c0 + 1);
      @(posedge clk);
      #1;
      chk("t6_vld",   int'(bus.cell_vld),  0);
      chk("t6_code",  int'(bus.cell_code), 0);
      chk("t6_busy",  int'(bus.busy),      0);
      chk("t6_ready", int'(bus.req_ready), 1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      t = cyc;
      schedule(t, 'h0C63, 'h7318, 1'b0, 0, -1);
      step();
      wait_idle();
      chk("t6_res_cycle", last_res_cyc, t + 18);

      for (int n = 0; n < 60; n++) begin
         s   = int'($urandom_range(0, 'h7FFF));
         e   = (n % 7 == 0) ? s : int'($urandom_range(0, 'h7FFF));
         sel = int'($urandom_range(0, 2));
         hen = (sel != 0);
         hc  = (sel == 1) ? qcell(s, e, int'($urandom_range(0, STEPS)))
                          : int'($urandom_range(0, 'h7FFF));
         aoff = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 19)) : -1;
         do_edge(s, e, hen, hc, aoff, t);
      end
      wait_idle();
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
